snake_game_sequencer: RTL

//  Top-level sequencer for the snake cartridge. Runs the game state machine (idle/clear/play/pause/over/won).

---
 rtl/snake_game_sequencer_pkg.sv | 31 +++
 rtl/snake_tick_gen.sv | 66 ++++++
 rtl/snake_game_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/snake_game_sequencer_pkg.sv
// Shared constants for the snake cartridge sequencer: direction codes, FSM
// encodings, default timing parameters and the tick counter width.
package snake_game_sequencer_pkg;

   localparam logic [1:0] DIR_LEFT  = 2'b00;
   localparam logic [1:0] DIR_TOP   = 2'b01;
   localparam logic [1:0] DIR_RIGHT = 2'b10;
   localparam logic [1:0] DIR_DOWN  = 2'b11;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CLEAR = 3'd1;
   localparam logic [2:0] ST_PLAY  = 3'd2;
   localparam logic [2:0] ST_PAUSE = 3'd3;
   localparam logic [2:0] ST_OVER  = 3'd4;
   localparam logic [2:0] ST_WON   = 3'd5;

   localparam int unsigned DEF_CLK_HZ     = 25_000_000;
   localparam int unsigned DEF_BASE_TICK  = 6_250_000;
   localparam int unsigned DEF_MIN_TICK   = 1_562_500;
   localparam int unsigned DEF_SPEED_STEP = 250_000;
   localparam int unsigned DEF_ROUND_SECS = 120;
   localparam int unsigned DEF_TAIL_W     = 6;

   localparam int unsigned TICK_W = $clog2(DEF_BASE_TICK + 1);

   // The snake may never turn straight back onto its own neck.
   function automatic logic [1:0] dir_reverse(input logic [1:0] d);
      return d ^ 2'b10;
   endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Game step tick generator: down-counter reloaded with a tail-dependent period,
// shrinking by SPEED_STEP per segment and saturating at MIN_TICK.
module snake_tick_gen
   import snake_game_sequencer_pkg::*;
#(
   parameter int unsigned BASE_TICK  = DEF_BASE_TICK,
   parameter int unsigned MIN_TICK   = DEF_MIN_TICK,
   parameter int unsigned SPEED_STEP = DEF_SPEED_STEP,
   parameter int unsigned TAIL_W     = DEF_TAIL_W
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic              enable_i,
   input  logic              load_i,
   input  logic [TAIL_W-1:0] tail_count_i,
   output logic              tick_o,
   output logic              pre_tick_c
);

   localparam int unsigned MAX_TICK = (BASE_TICK > MIN_TICK) ? BASE_TICK : MIN_TICK;
   localparam int unsigned CNT_W    = ($clog2(MAX_TICK + 1) > TICK_W) ? $clog2(MAX_TICK + 1) : TICK_W;
   localparam logic [31:0] HEADROOM = 32'(MAX_TICK - MIN_TICK);
   localparam logic [CNT_W-1:0] PERIOD0 = CNT_W'(MAX_TICK);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic [31:0]      step_prod_c;
   logic [CNT_W-1:0] period_c;

   // Saturating subtract: once the speed-up eats the headroom, hold at the floor.
   always_comb begin
      step_prod_c = 32'(SPEED_STEP) * 32'(tail_count_i);
      period_c    = (step_prod_c >= HEADROOM) ? CNT_W'(MIN_TICK)
                                              : CNT_W'(32'(MAX_TICK) - step_prod_c);
   end

   // Reload with period-1 so consecutive ticks sit exactly one period apart.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (load_i) begin
         cnt_d = PERIOD0;
      end else if (enable_i) begin
         if (cnt_q == '0) begin
            cnt_d  = period_c - CNT_W'(1);
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o     = tick_q;
   assign pre_tick_c = enable_i & (cnt_q == CNT_W'(1));

endmodule

// File: rtl/snake_game_sequencer.sv
// Snake cartridge sequencer: game FSM, button edge detection, direction
// filtering, round timer and the game_logic update tick.
module snake_game_sequencer
   import snake_game_sequencer_pkg::*;
#(
   parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
   parameter int unsigned BASE_TICK  = DEF_BASE_TICK,
   parameter int unsigned MIN_TICK   = DEF_MIN_TICK,
   parameter int unsigned SPEED_STEP = DEF_SPEED_STEP,
   parameter int unsigned ROUND_SECS = DEF_ROUND_SECS,
   parameter int unsigned TAIL_W     = DEF_TAIL_W
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic              btn_start_i,
   input  logic              btn_pause_i,
   input  logic [1:0]        dir_req_i,
   input  logic              dir_req_valid_i,
   input  logic              game_over_i,
   input  logic              game_won_i,
   input  logic [TAIL_W-1:0] tail_count_i,
   output logic              update_tick_o,
   output logic [1:0]        direction_o,
   output logic              logic_reset_o,
   output logic              time_max_flag_o,
   output logic [7:0]        seconds_left_o,
   output logic [2:0]        game_state_o
);

   localparam int unsigned PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);
   localparam logic [7:0] ROUND = 8'(ROUND_SECS);

   logic [2:0]         state_q, state_d;
   logic               clr_cnt_q, clr_cnt_d;
   logic               start_q, pause_q;
   logic [1:0]         dir_q, dir_d;
   logic [1:0]         pend_q, pend_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [7:0]         secs_q, secs_d;
   logic               tmax_q, tmax_d;
   logic               lreset_q, lreset_d;
   logic               start_edge_c, pause_edge_c, pre_tick_c, tick;

   assign start_edge_c = btn_start_i & ~start_q;
   assign pause_edge_c = btn_pause_i & ~pause_q;

   snake_tick_gen #(
      .BASE_TICK  (BASE_TICK),
      .MIN_TICK   (MIN_TICK),
      .SPEED_STEP (SPEED_STEP),
      .TAIL_W     (TAIL_W)
   ) u_tick_gen (
      .vga_clk      (vga_clk),
      .reset        (reset),
      .enable_i     (state_q == ST_PLAY),
      .load_i       (state_q == ST_CLEAR),
      .tail_count_i (tail_count_i),
      .tick_o       (tick),
      .pre_tick_c   (pre_tick_c)
   );

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      dir_d     = dir_q;
      pend_d    = pend_q;
      presc_d   = presc_q;
      secs_d    = secs_q;
      tmax_d    = tmax_q;
      case (state_q)
         ST_IDLE: begin
            if (start_edge_c) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = 1'b0;
            end
         end
         ST_CLEAR: begin
            secs_d    = ROUND;
            tmax_d    = 1'b0;
            dir_d     = DIR_RIGHT;
            pend_d    = DIR_RIGHT;
            presc_d   = '0;
            clr_cnt_d = 1'b1;
            if (clr_cnt_q) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (dir_req_valid_i && (dir_req_i != dir_reverse(dir_q))) pend_d = dir_req_i;
            if (pre_tick_c) dir_d = pend_q;
            if (presc_q == PRESC_MAX) begin
               presc_d = '0;
               if (secs_q != 8'd0) secs_d = secs_q - 8'd1;
            end else begin
               presc_d = presc_q + PRESC_W'(1);
            end
            if (secs_q == 8'd0) tmax_d = 1'b1;
            // Collision outranks a win or timeout, which outrank a pause request.
            if (game_over_i)                           state_d = ST_OVER;
            else if (game_won_i || (secs_q == 8'd0))   state_d = ST_WON;
            else if (pause_edge_c)                     state_d = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (pause_edge_c) state_d = ST_PLAY;
         end
         ST_OVER, ST_WON: begin
            if (start_edge_c) begin
               state_d   = ST_CLEAR;
               clr_cnt_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      lreset_d = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         clr_cnt_q <= 1'b0;
         start_q   <= 1'b0;
         pause_q   <= 1'b0;
         dir_q     <= DIR_RIGHT;
         pend_q    <= DIR_RIGHT;
         presc_q   <= '0;
         secs_q    <= ROUND;
         tmax_q    <= 1'b0;
         lreset_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         start_q   <= btn_start_i;
         pause_q   <= btn_pause_i;
         dir_q     <= dir_d;
         pend_q    <= pend_d;
         presc_q   <= presc_d;
         secs_q    <= secs_d;
         tmax_q    <= tmax_d;
         lreset_q  <= lreset_d;
      end
   end

   assign update_tick_o   = tick;
   assign direction_o     = dir_q;
   assign logic_reset_o   = lreset_q;
   assign time_max_flag_o = tmax_q;
   assign seconds_left_o  = secs_q;
   assign game_state_o    = state_q;

endmodule
